// File: rtl/burst_line_adapter_if.sv
// rtl/burst_line_adapter_if.sv - cache-side line port and memory-side burst port bundle
interface burst_line_adapter_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [BURST_W-1:0] mem_wdata;
    logic [BURST_W-1:0] mem_rdata;
    logic              mem_resp;
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    logic              mem_err;
`endif

    // Adapter view: takes line requests, drives memory bursts
    modport slave (
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
        output mem_err,
`endif
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
        output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    // Environment view: cache controller plus physical memory
    modport master (
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
        input  mem_err,
`endif
        output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
        input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/burst_line_adapter.sv
// rtl/burst_line_adapter.sv - line request to memory burst adapter; BURST_LINE_ADAPTER_TIMEOUT_EN adds mem_err and a per-beat wait timeout
module burst_line_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input logic                 clk,
    input logic                 rst,
    burst_line_adapter_if.slave bus
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFS) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]               r_count;
    logic [CNT_W-1:0]               w_count_next;
    logic [ADDR_W-1:0]              r_addr;
    // Shared line buffer: holds the writeback line, or assembles a fill
    logic [BEATS-1:0][BURST_W-1:0]  r_line;
    logic [BEATS-1:0][BURST_W-1:0]  w_line_fill;
    // Completed fill presented to the cache; only refreshed when a read ends
    logic [BEATS-1:0][BURST_W-1:0]  r_rdata;
    logic                           w_accept_wr;
    logic                           w_accept_rd;
    logic                           w_beat;

`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_err;
    logic              w_err_next;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, beat counter and datapath load strobes
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_accept_wr  = 1'b0;
        w_accept_rd  = 1'b0;
        w_beat       = 1'b0;
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
        w_wait_next  = r_wait;
        w_err_next   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // Writeback wins so a dirty victim leaves before its fill arrives
                if (bus.pmem_write) begin
                    w_accept_wr  = 1'b1;
                    w_count_next = '0;
                    w_state_next = WR_BURST;
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
                    w_wait_next  = '0;
`endif
                end else if (bus.pmem_read) begin
                    w_accept_rd  = 1'b1;
                    w_count_next = '0;
                    w_state_next = RD_BURST;
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
                    w_wait_next  = '0;
`endif
                end
            end
            RD_BURST, WR_BURST: begin
                if (bus.mem_resp) begin
                    w_beat       = 1'b1;
                    w_count_next = r_count + 1'b1;
                    if (r_count == LAST_BEAT) begin
                        w_state_next = DONE;
                    end
                end
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
                if (bus.mem_resp) begin
                    w_wait_next = '0;
                end else if (r_wait == WAIT_W'(TIMEOUT_CYCLES)) begin
                    w_state_next = DONE;
                    w_err_next   = 1'b1;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
`endif
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line buffer with the current read beat merged into its slot
    always_comb begin
        w_line_fill          = r_line;
        w_line_fill[r_count] = bus.mem_rdata;
    end

    // Address, line buffer, beat counter and completed-fill registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_accept_wr || w_accept_rd) begin
                r_addr <= bus.pmem_address & ALIGN_MASK;
            end
            if (w_accept_wr) begin
                r_line <= bus.pmem_wdata;
            end else if (w_beat && r_state == RD_BURST) begin
                r_line <= w_line_fill;
            end
            if (r_state == RD_BURST && w_state_next == DONE) begin
                r_rdata <= w_beat ? w_line_fill : r_line;
            end
        end
    end

`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    // Wait-state counter and error flag shown during the timed-out DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_wait_next;
            r_err  <= w_err_next;
        end
    end

    assign bus.mem_err = r_err;
`endif

    assign bus.mem_read    = (r_state == RD_BURST);
    assign bus.mem_write   = (r_state == WR_BURST);
    assign bus.pmem_resp   = (r_state == DONE);
    assign bus.mem_address = r_addr;
    assign bus.mem_wdata   = r_line[r_count];
    assign bus.pmem_rdata  = r_rdata;
endmodule

// File: tb/tb_burst_line_adapter.sv
// tb/tb_burst_line_adapter.sv - directed self-checking bench for burst_line_adapter
module tb_burst_line_adapter;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    burst_line_adapter_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    burst_line_adapter #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`else
    burst_line_adapter #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] rbeats [4];
    logic [63:0] wseen  [4];
    int          s_cycles;
    int          s_beats;
    int          s_active;
    logic        s_saw_rd;
    logic        s_saw_wr;
    logic [31:0] s_addr;

    // Memory responder: 'waits' idle cycles before each beat; records what it saw
    task automatic serve(input int waits);
        int wc;
        int b;
        wc = 0; b = 0;
        s_cycles = -1; s_active = 0; s_saw_rd = 1'b0; s_saw_wr = 1'b0; s_addr = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.pmem_resp) begin
                s_cycles = n;
                break;
            end
            if (bus.mem_read || bus.mem_write) begin
                if (s_active == 0) s_addr = bus.mem_address;
                s_active++;
                s_saw_rd = s_saw_rd | bus.mem_read;
                s_saw_wr = s_saw_wr | bus.mem_write;
                if (wc < waits) begin
                    bus.mem_resp = 1'b0;
                    wc++;
                end else if (b < 4) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = rbeats[b];
                    wseen[b]      = bus.mem_wdata;
                    b++;
                    wc = 0;
                end else begin
                    bus.mem_resp = 1'b0;
                end
            end else begin
                bus.mem_resp = 1'b0;
            end
        end
        s_beats = b;
        bus.mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); end
        total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); end
        total++; if (bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL rst_pmem_resp: got %b want 0", bus.pmem_resp); end
        total++; if (bus.mem_address !== 32'h0) begin bad++; $display("FAIL rst_mem_address: got %h want 0", bus.mem_address); end
        total++; if (bus.mem_wdata !== 64'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
        total++; if (bus.pmem_rdata !== 256'h0) begin bad++; $display("FAIL rst_pmem_rdata: got %h want 0", bus.pmem_rdata); end
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
        total++; if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL rst_mem_err: got %b want 0", bus.mem_err); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        rbeats = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        @(negedge clk);
        bus.pmem_address = 32'h0000_1234;
        bus.pmem_read    = 1'b1;
        serve(0);
        total++; if (s_cycles !== 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", s_cycles); end
        total++; if (s_addr !== 32'h0000_1220) begin bad++; $display("FAIL rd_address: got %h want 00001220", s_addr); end
        total++; if (s_active !== 4 || s_saw_wr !== 1'b0) begin bad++; $display("FAIL rd_active: got %0d/%b want 4/0", s_active, s_saw_wr); end
        total++; if (bus.pmem_rdata !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
            bad++; $display("FAIL rd_line: got %h", bus.pmem_rdata);
        end
        bus.pmem_read = 1'b0;
        @(negedge clk);
        total++; if (bus.pmem_resp !== 1'b0 || bus.mem_read !== 1'b0) begin bad++; $display("FAIL rd_after: resp %b rd %b want 0 0", bus.pmem_resp, bus.mem_read); end
    endtask

    task automatic test_write_waits();
        logic [63:0] exp_w [4];
        exp_w = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A55A5A5A5A, 64'hDEADBEEFCAFEF00D};
        @(negedge clk);
        bus.pmem_address = 32'h0000_8FFF;
        bus.pmem_wdata   = 256'hDEADBEEFCAFEF00D_A5A5A5A55A5A5A5A_FEDCBA9876543210_0123456789ABCDEF;
        bus.pmem_write   = 1'b1;
        serve(2);
        total++; if (s_cycles !== 13) begin bad++; $display("FAIL wr_latency: got %0d want 13", s_cycles); end
        total++; if (s_active !== 12 || s_saw_rd !== 1'b0) begin bad++; $display("FAIL wr_active: got %0d/%b want 12/0", s_active, s_saw_rd); end
        total++; if (s_addr !== 32'h0000_8FE0) begin bad++; $display("FAIL wr_address: got %h want 00008FE0", s_addr); end
        for (int i = 0; i < 4; i++) begin
            total++; if (wseen[i] !== exp_w[i]) begin bad++; $display("FAIL wr_beat%0d: got %h want %h", i, wseen[i], exp_w[i]); end
        end
        total++; if (bus.pmem_rdata !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
            bad++; $display("FAIL wr_rdata_stable: got %h", bus.pmem_rdata);
        end
        bus.pmem_write = 1'b0;
        @(negedge clk);
        total++; if (bus.pmem_resp !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL wr_single_pulse: resp %b wr %b want 0 0", bus.pmem_resp, bus.mem_write); end
    endtask

    task automatic test_back_to_back();
        rbeats = '{64'hB000_0000_0000_0001, 64'hB000_0000_0000_0002, 64'hB000_0000_0000_0003, 64'hB000_0000_0000_0004};
        @(negedge clk);
        bus.pmem_address = 32'h0000_0100;
        bus.pmem_wdata   = 256'hC3C3C3C3C3C3C3C3_C2C2C2C2C2C2C2C2_C1C1C1C1C1C1C1C1_C0C0C0C0C0C0C0C0;
        bus.pmem_write   = 1'b1;
        serve(0);
        total++; if (s_cycles !== 5 || s_beats !== 4) begin bad++; $display("FAIL b2b_wr: got %0d/%0d want 5/4", s_cycles, s_beats); end
        total++; if (wseen[3] !== 64'hC3C3C3C3C3C3C3C3 || wseen[0] !== 64'hC0C0C0C0C0C0C0C0) begin
            bad++; $display("FAIL b2b_wr_beats: got %h %h", wseen[0], wseen[3]);
        end
        bus.pmem_write   = 1'b0;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_0240;
        serve(0);
        total++; if (s_cycles !== 6) begin bad++; $display("FAIL b2b_rd_latency: got %0d want 6", s_cycles); end
        total++; if (s_saw_wr !== 1'b0 || s_active !== 4) begin bad++; $display("FAIL b2b_rd_active: got %b/%0d want 0/4", s_saw_wr, s_active); end
        total++; if (s_addr !== 32'h0000_0240) begin bad++; $display("FAIL b2b_rd_address: got %h want 00000240", s_addr); end
        total++; if (bus.pmem_rdata !== 256'hB000000000000004_B000000000000003_B000000000000002_B000000000000001) begin
            bad++; $display("FAIL b2b_rd_line: got %h", bus.pmem_rdata);
        end
        bus.pmem_read = 1'b0;
    endtask

    task automatic test_simultaneous_spurious();
        @(negedge clk);
        bus.pmem_address = 32'h0000_0060;
        bus.pmem_wdata   = 256'h0000000000000D03_0000000000000D02_0000000000000D01_0000000000000D00;
        bus.pmem_read    = 1'b1;
        bus.pmem_write   = 1'b1;
        serve(0);
        total++; if (s_saw_wr !== 1'b1 || s_saw_rd !== 1'b0) begin bad++; $display("FAIL sim_priority: wr %b rd %b want 1 0", s_saw_wr, s_saw_rd); end
        total++; if (s_cycles !== 5 || wseen[2] !== 64'h0000000000000D02) begin bad++; $display("FAIL sim_write: got %0d %h want 5 0000000000000d02", s_cycles, wseen[2]); end
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.pmem_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
                bad++; $display("FAIL spurious%0d: resp %b rd %b wr %b want 0 0 0", i, bus.pmem_resp, bus.mem_read, bus.mem_write);
            end
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = 64'hEEEEEEEEEEEEEEEE;
        end
        @(negedge clk);
        bus.mem_resp = 1'b0;
        total++; if (bus.pmem_resp !== 1'b0 || bus.pmem_rdata !== 256'hB000000000000004_B000000000000003_B000000000000002_B000000000000001) begin
            bad++; $display("FAIL spurious_idle: resp %b rdata %h", bus.pmem_resp, bus.pmem_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        bus.pmem_address = 32'h0000_2000;
        bus.pmem_read    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL mid_rd_beat%0d: mem_read %b want 1", i, bus.mem_read); end
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = 64'h9999999999999999;
        end
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.pmem_read = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (bus.mem_read !== 1'b0 || bus.pmem_resp !== 1'b0 || bus.mem_address !== 32'h0) begin
            bad++; $display("FAIL mid_rst_ctrl: rd %b resp %b addr %h want 0 0 0", bus.mem_read, bus.pmem_resp, bus.mem_address);
        end
        total++; if (bus.pmem_rdata !== 256'h0 || bus.mem_wdata !== 64'h0) begin
            bad++; $display("FAIL mid_rst_data: rdata %h wdata %h want 0 0", bus.pmem_rdata, bus.mem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.pmem_resp !== 1'b0 || bus.mem_read !== 1'b0) begin
                bad++; $display("FAIL mid_abandon%0d: resp %b rd %b want 0 0", i, bus.pmem_resp, bus.mem_read);
            end
        end
        rbeats = '{64'h0A0A0A0A0A0A0A0A, 64'h0B0B0B0B0B0B0B0B, 64'h0C0C0C0C0C0C0C0C, 64'h0D0D0D0D0D0D0D0D};
        bus.pmem_address = 32'h3FFF_FFE7;
        bus.pmem_read    = 1'b1;
        serve(1);
        total++; if (s_cycles !== 9) begin bad++; $display("FAIL mid_new_latency: got %0d want 9", s_cycles); end
        total++; if (s_addr !== 32'h3FFF_FFE0) begin bad++; $display("FAIL mid_new_address: got %h want 3fffffe0", s_addr); end
        total++; if (bus.pmem_rdata !== 256'h0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C_0B0B0B0B0B0B0B0B_0A0A0A0A0A0A0A0A) begin
            bad++; $display("FAIL mid_new_line: got %h", bus.pmem_rdata);
        end
        bus.pmem_read = 1'b0;
        @(negedge clk);
    endtask

`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
    task automatic test_timeout();
        int   first_rd;
        int   resp_n;
        logic err_at_resp;
        first_rd = -1; resp_n = -1; err_at_resp = 1'b0;
        @(negedge clk);
        bus.pmem_address = 32'h0000_0500;
        bus.pmem_read    = 1'b1;
        bus.mem_resp     = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.mem_read && first_rd < 0) first_rd = n;
            if (bus.pmem_resp) begin
                resp_n      = n;
                err_at_resp = bus.mem_err;
                break;
            end
        end
        bus.pmem_read = 1'b0;
        total++; if (first_rd < 0 || resp_n - first_rd !== 9) begin bad++; $display("FAIL to_latency: got %0d want 9", resp_n - first_rd); end
        total++; if (err_at_resp !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_at_resp); end
        @(negedge clk);
        total++; if (bus.pmem_resp !== 1'b0 || bus.mem_err !== 1'b0 || bus.mem_read !== 1'b0) begin
            bad++; $display("FAIL to_idle: resp %b err %b rd %b want 0 0 0", bus.pmem_resp, bus.mem_err, bus.mem_read);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.mem_rdata    = '0;
        bus.mem_resp     = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_back_to_back();
        test_simultaneous_spurious();
        test_reset_mid_read();
`ifdef BURST_LINE_ADAPTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
